ufm_page_req_ctrl: RTL and testbench

Sits directly downstream of the 2-flop request synchronizer inside UFMRwPageDecode. It consumes the synchronized page-request level, glitch-filters it, and converts each rising edge into one UFM page read/write command. It then waits for UFM completion or a timeout, and returns a 4-phase level handshake (ack/err) to the requester.

---
 rtl/ufm_ctrl_pkg.sv | 15 +
 rtl/ufm_req_filter.sv | 40 ++++
 rtl/ufm_page_req_ctrl.sv | 122 ++++++++++++
 tb/tb_ufm_page_req_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ufm_ctrl_pkg.sv
// Shared constants and FSM state encoding for the UFM page request controller.
package ufm_ctrl_pkg;

    localparam int DEB_LEN_DEF = 3;
    localparam int TMO_MAX_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_ACK       = 3'd3,
        ST_ERR       = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/ufm_req_filter.sv
// Glitch filter for the synchronized request level: saturating debounce count
// plus a rising-edge detect on the filtered level.
module ufm_req_filter
    import ufm_ctrl_pkg::*;
#(
    parameter int DEB_LEN = DEB_LEN_DEF
) (
    input  logic sync_clk,
    input  logic sync_rst_n,
    input  logic clk_en_i,
    input  logic req_sync_i,
    output logic req_valid_o,
    output logic req_start_o
);

    localparam logic [3:0] DEB_MAX = 4'(DEB_LEN);

    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic       req_valid_q;

    always_comb begin
        deb_cnt_d = 4'd0;
        if (req_sync_i)
            deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 4'd1;
    end

    always_ff @(posedge sync_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            deb_cnt_q   <= 4'd0;
            req_valid_q <= 1'b0;
        end else if (clk_en_i) begin
            deb_cnt_q   <= deb_cnt_d;
            req_valid_q <= req_valid_o;
        end
    end

    assign req_valid_o = (deb_cnt_q == DEB_MAX);
    assign req_start_o = req_valid_o & ~req_valid_q;

endmodule

// File: rtl/ufm_page_req_ctrl.sv
// Turns each filtered request edge into one UFM page command, waits for
// completion or timeout, and returns a level ack/err handshake.
module ufm_page_req_ctrl
    import ufm_ctrl_pkg::*;
#(
    parameter int PAGE_W  = 8,
    parameter int DEB_LEN = DEB_LEN_DEF,
    parameter int TMO_W   = 10,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic              sync_clk,
    input  logic              sync_rst_n,
    input  logic              sync_clk_en,
    input  logic              req_sync,
    input  logic              req_wr,
    input  logic [PAGE_W-1:0] page_addr,
    input  logic              ufm_busy,
    input  logic              ufm_done,
    output logic              ufm_cmd_vld,
    output logic              ufm_cmd_wr,
    output logic [PAGE_W-1:0] ufm_page,
    output logic              req_ack,
    output logic              req_err,
    output logic              ctrl_busy
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

    logic req_valid, req_start;

    ufm_req_filter #(.DEB_LEN(DEB_LEN)) u_filter (
        .sync_clk    (sync_clk),
        .sync_rst_n  (sync_rst_n),
        .clk_en_i    (sync_clk_en),
        .req_sync_i  (req_sync),
        .req_valid_o (req_valid),
        .req_start_o (req_start)
    );

    ctrl_state_e       state_q, state_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic              vld_q, vld_d, wr_q, wr_d, ack_q, ack_d, err_q, err_d;
    logic [PAGE_W-1:0] page_q, page_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        vld_d   = vld_q;
        wr_d    = wr_q;
        page_d  = page_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (req_start) begin
                page_d  = page_addr;
                wr_d    = req_wr;
                err_d   = 1'b0;
                timer_d = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                timer_d = timer_q + 1'b1;
                if (!ufm_busy) begin
                    vld_d   = 1'b1;
                    state_d = ST_WAIT_DONE;
                end else if (timer_d == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_WAIT_DONE: begin
                vld_d   = 1'b0;
                timer_d = timer_q + 1'b1;
                if (ufm_done) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                // >= also catches an issue on the very cycle the limit was hit
                end else if (timer_d >= TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_ACK: begin
                ack_d = 1'b1;
                if (!req_valid) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: if (!req_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sync_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            vld_q   <= 1'b0;
            wr_q    <= 1'b0;
            page_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (sync_clk_en) begin
            state_q <= state_d;
            timer_q <= timer_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            page_q  <= page_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ufm_cmd_vld = vld_q;
    assign ufm_cmd_wr  = wr_q;
    assign ufm_page    = page_q;
    assign req_ack     = ack_q;
    assign req_err     = err_q;
    assign ctrl_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ufm_page_req_ctrl.sv
// Directed bench for ufm_page_req_ctrl with hand-computed expectations.
module tb_ufm_page_req_ctrl;

    logic       sync_clk = 1'b0;
    logic       sync_rst_n = 1'b0;
    logic       sync_clk_en = 1'b1;
    logic       req_sync = 1'b0, req_wr = 1'b0, ufm_busy = 1'b0, ufm_done = 1'b0;
    logic [7:0] page_addr = 8'h00;
    logic       ufm_cmd_vld, ufm_cmd_wr, req_ack, req_err, ctrl_busy;
    logic [7:0] ufm_page;

    int checks = 0;
    int errors = 0;

    ufm_page_req_ctrl #(.PAGE_W(8), .DEB_LEN(3), .TMO_W(10), .TMO_MAX(1000)) dut (
        .sync_clk    (sync_clk),
        .sync_rst_n  (sync_rst_n),
        .sync_clk_en (sync_clk_en),
        .req_sync    (req_sync),
        .req_wr      (req_wr),
        .page_addr   (page_addr),
        .ufm_busy    (ufm_busy),
        .ufm_done    (ufm_done),
        .ufm_cmd_vld (ufm_cmd_vld),
        .ufm_cmd_wr  (ufm_cmd_wr),
        .ufm_page    (ufm_page),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .ctrl_busy   (ctrl_busy)
    );

    always #5 sync_clk = ~sync_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sync_clk);
    endtask

    // one enabled edge followed by one disabled edge
    task automatic estep(input int n);
        repeat (n) begin
            sync_clk_en = 1'b1;
            @(negedge sync_clk);
            sync_clk_en = 1'b0;
            @(negedge sync_clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".vld"},  ufm_cmd_vld, 0);
        chk({tag, ".wr"},   ufm_cmd_wr, 0);
        chk({tag, ".page"}, ufm_page, 0);
        chk({tag, ".ack"},  req_ack, 0);
        chk({tag, ".err"},  req_err, 0);
        chk({tag, ".busy"}, ctrl_busy, 0);
    endtask

    initial begin
        #1 chk_all_zero("reset");
        step(2);
        sync_rst_n = 1'b1;
        step(1);

        // read: command 5 edges after req rises
        req_sync = 1'b1; page_addr = 8'h5A; req_wr = 1'b0;
        step(4);
        chk("rd.vld_early", ufm_cmd_vld, 0);
        chk("rd.busy_issue", ctrl_busy, 1);
        step(1);
        chk("rd.vld", ufm_cmd_vld, 1);
        chk("rd.page", ufm_page, 8'h5A);
        chk("rd.wr", ufm_cmd_wr, 0);
        page_addr = 8'hFF;
        step(1);
        chk("rd.vld_one", ufm_cmd_vld, 0);
        step(3);
        ufm_done = 1'b1; step(1); ufm_done = 1'b0;
        chk("rd.ack", req_ack, 1);
        chk("rd.err", req_err, 0);
        req_sync = 1'b0;
        step(2);
        chk("rd.ack_clr", req_ack, 0);
        chk("rd.idle", ctrl_busy, 0);
        chk("rd.page_hold", ufm_page, 8'h5A);

        // done while idle is ignored
        ufm_done = 1'b1; step(1); ufm_done = 1'b0;
        chk("idle_done.ack", req_ack, 0);

        // glitch of 2 cycles rejected
        req_sync = 1'b1; step(2); req_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("glitch.vld", ufm_cmd_vld, 0);
            chk("glitch.busy", ctrl_busy, 0);
        end

        // busy forever -> timeout at timer 1000
        ufm_busy = 1'b1; req_sync = 1'b1;
        step(4);
        step(999);
        chk("tmo.err_early", req_err, 0);
        chk("tmo.busy", ctrl_busy, 1);
        step(1);
        chk("tmo.err", req_err, 1);
        chk("tmo.vld", ufm_cmd_vld, 0);
        req_sync = 1'b0; ufm_busy = 1'b0;
        step(2);
        chk("tmo.idle", ctrl_busy, 0);
        chk("tmo.err_hold", req_err, 1);
        req_sync = 1'b1; page_addr = 8'hA3; req_wr = 1'b1;
        step(4);
        chk("tmo.err_clr", req_err, 0);
        step(1);
        chk("wr.vld", ufm_cmd_vld, 1);
        chk("wr.page", ufm_page, 8'hA3);
        chk("wr.wr", ufm_cmd_wr, 1);
        req_sync = 1'b0;
        step(2);
        ufm_done = 1'b1; step(1); ufm_done = 1'b0;
        chk("drop.ack", req_ack, 1);
        step(1);
        chk("drop.ack_1cyc", req_ack, 0);
        chk("drop.idle", ctrl_busy, 0);

        // done on the same cycle the timer hits the limit
        req_sync = 1'b1; req_wr = 1'b0; page_addr = 8'h11;
        step(5);
        chk("coll.vld", ufm_cmd_vld, 1);
        step(998);
        chk("coll.pre_ack", req_ack, 0);
        chk("coll.pre_err", req_err, 0);
        ufm_done = 1'b1; step(1); ufm_done = 1'b0;
        chk("coll.ack", req_ack, 1);
        chk("coll.err", req_err, 0);
        req_sync = 1'b0; step(2);
        chk("coll.idle", ctrl_busy, 0);

        // enable gating
        req_sync = 1'b1; page_addr = 8'h3C;
        estep(4);
        chk("en.vld_early", ufm_cmd_vld, 0);
        estep(1);
        chk("en.vld_hold", ufm_cmd_vld, 1);
        chk("en.page", ufm_page, 8'h3C);
        estep(1);
        chk("en.vld_one", ufm_cmd_vld, 0);
        ufm_done = 1'b1; estep(1); ufm_done = 1'b0;
        chk("en.ack", req_ack, 1);
        req_sync = 1'b0; estep(2);
        chk("en.idle", ctrl_busy, 0);
        sync_clk_en = 1'b1;

        // reset in WAIT_DONE with request held
        req_sync = 1'b1; page_addr = 8'h77; req_wr = 1'b1;
        step(7);
        chk("rst.busy_pre", ctrl_busy, 1);
        sync_rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        step(1);
        sync_rst_n = 1'b1;
        step(4);
        chk("rst.vld_early", ufm_cmd_vld, 0);
        step(1);
        chk("rst.vld", ufm_cmd_vld, 1);
        chk("rst.page", ufm_page, 8'h77);
        ufm_done = 1'b1; step(1); ufm_done = 1'b0;
        chk("rst.ack", req_ack, 1);
        req_sync = 1'b0; step(2);
        chk("rst.idle", ctrl_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
